// File: rtl/mil_bc_sched.sv
// Bus-controller message scheduler: sends a command word (plus FIFO data for BC->RT), then waits for
// the RT status with a timeout, retries on faults and forwards RT->BC data words to the host.
`timescale 1ns/1ps
module mil_bc_sched #(
  parameter int unsigned TIMEOUT_CYC = 700,
  parameter int unsigned MAX_RETRY   = 1
) (
  input  logic        clk,
  input  logic        R,
  input  logic        start,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  sub_addr,
  input  logic        tr,
  input  logic [4:0]  wc,
  input  logic        wr_en,
  input  logic [15:0] wr_dat,
  output logic [5:0]  fifo_cnt,
  output logic        txen,
  output logic [15:0] tx_dat,
  output logic        tx_cw,
  input  logic        en_tx,
  input  logic        T_end,
  input  logic        ok_rx,
  input  logic [15:0] sr_dat,
  input  logic        CW_DW,
  output logic [15:0] rd_dat,
  output logic        rd_vld,
  output logic [15:0] status_word,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {StIdle, StTxCw, StTxDw, StWaitSw, StRxDw, StDone} state_e;

  logic [15:0] mem_q [32];
  logic [5:0]  wr_ptr_q, rd_ptr_q, wk_ptr_q;
  state_e      state_q;
  logic [15:0] cw_q;
  logic        sent_q;
  logic [5:0]  cnt_q;
  logic [15:0] timer_q;
  logic [1:0]  retry_q;

  logic [5:0]  n_in, n_words;
  logic [15:0] timer_inc;
  logic        tmo, fault, can_retry;
  logic [1:0]  fault_code;

  // Count is measured against the committed pointer, so unacknowledged words stay queued.
  assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
  assign n_in      = {wc == 5'd0, wc};
  assign n_words   = {cw_q[4:0] == 5'd0, cw_q[4:0]};
  assign timer_inc = timer_q + 16'd1;
  assign tmo       = (timer_inc == 16'(TIMEOUT_CYC));
  assign can_retry = (32'(retry_q) < MAX_RETRY);

  always_comb begin
    fault      = 1'b0;
    fault_code = 2'b00;
    if (state_q == StWaitSw) begin
      if (ok_rx && CW_DW) begin
        if (sr_dat[15:11] != cw_q[15:11]) begin
          fault      = 1'b1;
          fault_code = 2'b10;
        end
      end else if (tmo) begin
        fault      = 1'b1;
        fault_code = 2'b01;
      end
    end else if (state_q == StRxDw) begin
      if (ok_rx) begin
        if (CW_DW) begin
          fault      = 1'b1;
          fault_code = 2'b10;
        end
      end else if (tmo) begin
        fault      = 1'b1;
        fault_code = 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (fifo_cnt != 6'd32)) mem_q[wr_ptr_q[4:0]] <= wr_dat;
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      wr_ptr_q <= '0;
    end else if (wr_en && (fifo_cnt != 6'd32)) begin
      wr_ptr_q <= wr_ptr_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      wk_ptr_q    <= '0;
      cw_q        <= '0;
      sent_q      <= 1'b0;
      cnt_q       <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      txen        <= 1'b0;
      tx_dat      <= '0;
      tx_cw       <= 1'b0;
      rd_dat      <= '0;
      rd_vld      <= 1'b0;
      status_word <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 2'b00;
    end else begin
      txen   <= 1'b0;
      rd_vld <= 1'b0;
      done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cw_q     <= {rt_addr, tr, sub_addr, wc};
            busy     <= 1'b1;
            err      <= 2'b00;
            retry_q  <= '0;
            wk_ptr_q <= rd_ptr_q;
            sent_q   <= 1'b0;
            if (!tr && (fifo_cnt < n_in)) begin
              err     <= 2'b11;
              state_q <= StDone;
            end else begin
              state_q <= StTxCw;
            end
          end
        end
        StTxCw: begin
          if (!sent_q) begin
            if (!en_tx) begin
              txen   <= 1'b1;
              tx_dat <= cw_q;
              tx_cw  <= 1'b1;
              sent_q <= 1'b1;
            end
          end else if (T_end) begin
            if (cw_q[10]) begin
              state_q <= StWaitSw;
              timer_q <= '0;
            end else begin
              state_q  <= StTxDw;
              txen     <= 1'b1;
              tx_dat   <= mem_q[wk_ptr_q[4:0]];
              tx_cw    <= 1'b0;
              wk_ptr_q <= wk_ptr_q + 6'd1;
              cnt_q    <= 6'd1;
            end
          end
        end
        StTxDw: begin
          if (T_end) begin
            if (cnt_q == n_words) begin
              state_q <= StWaitSw;
              timer_q <= '0;
            end else begin
              txen     <= 1'b1;
              tx_dat   <= mem_q[wk_ptr_q[4:0]];
              wk_ptr_q <= wk_ptr_q + 6'd1;
              cnt_q    <= cnt_q + 6'd1;
            end
          end
        end
        StWaitSw, StRxDw: begin
          timer_q <= timer_inc;
          if (state_q == StWaitSw && ok_rx && CW_DW) status_word <= sr_dat;
          if (fault) begin
            if (can_retry) begin
              retry_q  <= retry_q + 2'd1;
              wk_ptr_q <= rd_ptr_q;
              sent_q   <= 1'b0;
              state_q  <= StTxCw;
            end else begin
              err     <= fault_code;
              state_q <= StDone;
            end
          end else if (state_q == StWaitSw) begin
            if (ok_rx && CW_DW) begin
              if (cw_q[10]) begin
                state_q <= StRxDw;
                timer_q <= '0;
                cnt_q   <= '0;
              end else begin
                rd_ptr_q <= wk_ptr_q;
                state_q  <= StDone;
              end
            end
          end else if (ok_rx && !CW_DW) begin
            rd_dat  <= sr_dat;
            rd_vld  <= 1'b1;
            timer_q <= '0;
            cnt_q   <= cnt_q + 6'd1;
            if ((cnt_q + 6'd1) == n_words) state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mil_bc_sched.sv
// Scoreboard bench for mil_bc_sched with a transmitter model and scripted receiver responses.
`timescale 1ns/1ps
module tb_mil_bc_sched;

  localparam int WORD_CYC = 20;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  rt_addr = '0, sub_addr = '0, wc = '0;
  logic        tr = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_dat = '0;
  logic [5:0]  fifo_cnt;
  logic        txen, tx_cw;
  logic [15:0] tx_dat;
  logic        en_tx = 1'b0, T_end = 1'b0, ok_rx = 1'b0, CW_DW = 1'b0;
  logic [15:0] sr_dat = '0;
  logic [15:0] rd_dat, status_word;
  logic        rd_vld, busy, done;
  logic [1:0]  err;

  typedef struct packed {logic [15:0] dat; logic cw;} txw_t;
  txw_t        exp_tx[$];
  logic [15:0] exp_rd[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tx_left  = 0;
  int last_tend = 0;
  logic tend_prev = 1'b0;

  mil_bc_sched #(.TIMEOUT_CYC(700), .MAX_RETRY(1)) dut (
    .clk(clk), .R(R), .start(start), .rt_addr(rt_addr), .sub_addr(sub_addr), .tr(tr), .wc(wc),
    .wr_en(wr_en), .wr_dat(wr_dat), .fifo_cnt(fifo_cnt), .txen(txen), .tx_dat(tx_dat),
    .tx_cw(tx_cw), .en_tx(en_tx), .T_end(T_end), .ok_rx(ok_rx), .sr_dat(sr_dat), .CW_DW(CW_DW),
    .rd_dat(rd_dat), .rd_vld(rd_vld), .status_word(status_word), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model and scoreboard pops for transmitted and forwarded words.
  always @(negedge clk) begin
    txw_t e;
    logic [15:0] r;
    tend_prev = T_end;
    T_end = 1'b0;
    if (!R) begin
      en_tx = 1'b0;
      tx_left = 0;
    end else begin
      if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) begin
          T_end = 1'b1;
          en_tx = 1'b0;
          last_tend = cyc;
        end
      end
      if (txen) begin
        n_checks++;
        if (exp_tx.size() == 0) begin
          $display("FAIL tx_unexpected: got %h cw=%b, wanted no word", tx_dat, tx_cw);
        end else begin
          e = exp_tx.pop_front();
          if ({tx_dat, tx_cw} !== e)
            $display("FAIL tx_word: got %h cw=%b, wanted %h cw=%b", tx_dat, tx_cw, e.dat, e.cw);
          else n_pass++;
        end
        if (!tx_cw) begin
          n_checks++;
          if (tend_prev !== 1'b1)
            $display("FAIL tx_b2b: data txen got prev T_end=%b, wanted 1", tend_prev);
          else n_pass++;
        end
        en_tx = 1'b1;
        tx_left = WORD_CYC;
      end
    end
    if (rd_vld) begin
      n_checks++;
      if (exp_rd.size() == 0) begin
        $display("FAIL rd_unexpected: got %h, wanted no word", rd_dat);
      end else begin
        r = exp_rd.pop_front();
        if (rd_dat !== r) $display("FAIL rd_word: got %h, wanted %h", rd_dat, r);
        else n_pass++;
      end
    end
  end

  task automatic wr(input logic [15:0] d);
    wr_dat = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] rt, input logic [4:0] sa, input logic t, input logic [4:0] w);
    rt_addr = rt; sub_addr = sa; tr = t; wc = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rx(input logic [15:0] d, input logic c);
    sr_dat = d; CW_DW = c; ok_rx = 1'b1;
    @(negedge clk);
    ok_rx = 1'b0;
  endtask

  task automatic wait_tx(input int left, output bit ok);
    int k = 0;
    while (!(exp_tx.size() == left && tx_left == 0 && !T_end) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 5000);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    R = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({txen, tx_cw, rd_vld, busy, done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b, wanted 00000", {txen, tx_cw, rd_vld, busy, done});
    else n_pass++;
    n_checks++;
    if ({tx_dat, rd_dat, status_word} !== 48'h0)
      $display("FAIL reset_data: got %h, wanted 0", {tx_dat, rd_dat, status_word});
    else n_pass++;
    n_checks++;
    if ({fifo_cnt, err} !== 8'h0) $display("FAIL reset_cnt_err: got %h, wanted 0", {fifo_cnt, err});
    else n_pass++;
    R = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bc_rt();
    bit ok;
    int n;
    wr(16'h1111);
    wr(16'h2222);
    n_checks++;
    if (fifo_cnt !== 6'd2) $display("FAIL bcrt_cnt_load: got %0d, wanted 2", fifo_cnt);
    else n_pass++;
    exp_tx.push_back('{16'h2862, 1'b1});
    exp_tx.push_back('{16'h1111, 1'b0});
    exp_tx.push_back('{16'h2222, 1'b0});
    go(5'd5, 5'd3, 1'b0, 5'd2);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL bcrt_busy: got %b, wanted 1", busy);
    else n_pass++;
    wait_tx(0, ok);
    n_checks++;
    if (!ok) $display("FAIL bcrt_tx_wait: got %0d words left, wanted 0", exp_tx.size());
    else n_pass++;
    repeat (200) @(negedge clk);
    rx(16'h2800, 1'b1);
    wait_done(50, n);
    n_checks++;
    if (done !== 1'b1 || err !== 2'b00)
      $display("FAIL bcrt_done: got done=%b err=%b, wanted done=1 err=00", done, err);
    else n_pass++;
    n_checks++;
    if (fifo_cnt !== 6'd0 || status_word !== 16'h2800)
      $display("FAIL bcrt_after: got cnt=%0d sw=%h, wanted cnt=0 sw=2800", fifo_cnt, status_word);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rt_bc();
    bit ok;
    int n;
    exp_tx.push_back('{16'h2C23, 1'b1});
    exp_rd.push_back(16'h000A);
    exp_rd.push_back(16'h000B);
    exp_rd.push_back(16'h000C);
    go(5'd5, 5'd1, 1'b1, 5'd3);
    repeat (3) @(negedge clk);
    go(5'd7, 5'd2, 1'b0, 5'd1);  // ignored while busy
    wait_tx(0, ok);
    n_checks++;
    if (!ok) $display("FAIL rtbc_tx_wait: got %0d words left, wanted 0", exp_tx.size());
    else n_pass++;
    repeat (10) @(negedge clk);
    rx(16'h0BAD, 1'b0);
    repeat (5) @(negedge clk);
    rx(16'h2800, 1'b1);
    repeat (5) @(negedge clk);
    rx(16'h000A, 1'b0);
    repeat (4) @(negedge clk);
    rx(16'h000B, 1'b0);
    repeat (4) @(negedge clk);
    rx(16'h000C, 1'b0);
    wait_done(50, n);
    n_checks++;
    if (done !== 1'b1 || err !== 2'b00)
      $display("FAIL rtbc_done: got done=%b err=%b, wanted done=1 err=00", done, err);
    else n_pass++;
    n_checks++;
    if (exp_rd.size() != 0) $display("FAIL rtbc_rd_left: got %0d pending, wanted 0", exp_rd.size());
    else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++;
    if (exp_tx.size() != 0 || busy !== 1'b0)
      $display("FAIL rtbc_idle: got left=%0d busy=%b, wanted 0 0", exp_tx.size(), busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    wr(16'h3333);
    exp_tx.push_back('{16'h2861, 1'b1});
    exp_tx.push_back('{16'h3333, 1'b0});
    exp_tx.push_back('{16'h2861, 1'b1});
    exp_tx.push_back('{16'h3333, 1'b0});
    go(5'd5, 5'd3, 1'b0, 5'd1);
    wait_tx(0, ok);
    n_checks++;
    if (!ok) $display("FAIL tmo_tx_wait: got %0d words left, wanted 0", exp_tx.size());
    else n_pass++;
    wait_done(800, n);
    n_checks++;
    if (done !== 1'b1 || err !== 2'b01)
      $display("FAIL tmo_done: got done=%b err=%b, wanted done=1 err=01", done, err);
    else n_pass++;
    n_checks++;
    if ((cyc - last_tend) < 700 || (cyc - last_tend) > 704)
      $display("FAIL tmo_latency: got %0d cycles, wanted 700..704", cyc - last_tend);
    else n_pass++;
    n_checks++;
    if (fifo_cnt !== 6'd1) $display("FAIL tmo_cnt: got %0d, wanted 1", fifo_cnt);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mismatch();
    bit ok;
    int n;
    exp_tx.push_back('{16'h2C01, 1'b1});
    exp_tx.push_back('{16'h2C01, 1'b1});
    go(5'd5, 5'd0, 1'b1, 5'd1);
    wait_tx(1, ok);
    repeat (10) @(negedge clk);
    rx(16'h3000, 1'b1);
    wait_tx(0, ok);
    n_checks++;
    if (!ok) $display("FAIL mis_tx_wait: got %0d words left, wanted 0", exp_tx.size());
    else n_pass++;
    repeat (10) @(negedge clk);
    rx(16'h3000, 1'b1);
    wait_done(20, n);
    n_checks++;
    if (done !== 1'b1 || err !== 2'b10)
      $display("FAIL mis_done: got done=%b err=%b, wanted done=1 err=10", done, err);
    else n_pass++;
    n_checks++;
    if (status_word !== 16'h3000) $display("FAIL mis_status: got %h, wanted 3000", status_word);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_underflow();
    n_checks++;
    if (fifo_cnt !== 6'd1) $display("FAIL uf_cnt_pre: got %0d, wanted 1", fifo_cnt);
    else n_pass++;
    go(5'd5, 5'd3, 1'b0, 5'd4);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL uf_cycle1: got busy=%b done=%b, wanted 1 0", busy, done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || err !== 2'b11)
      $display("FAIL uf_done: got done=%b err=%b, wanted done=1 err=11", done, err);
    else n_pass++;
    for (int i = 0; i < 31; i++) wr(16'h0100 + 16'(i));
    n_checks++;
    if (fifo_cnt !== 6'd32) $display("FAIL fifo_full: got %0d, wanted 32", fifo_cnt);
    else n_pass++;
    wr(16'hDEAD);
    n_checks++;
    if (fifo_cnt !== 6'd32) $display("FAIL fifo_overflow: got %0d, wanted 32", fifo_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    bit saw_done;
    R = 1'b0;
    @(negedge clk);
    R = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_cnt !== 6'd0) $display("FAIL rst_fifo_clear: got %0d, wanted 0", fifo_cnt);
    else n_pass++;
    wr(16'h4444);
    wr(16'h5555);
    exp_tx.push_back('{16'h2862, 1'b1});
    exp_tx.push_back('{16'h4444, 1'b0});
    exp_tx.push_back('{16'h5555, 1'b0});
    go(5'd5, 5'd3, 1'b0, 5'd2);
    k = 0;
    while (exp_tx.size() != 1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 500) $display("FAIL rst_reach_dw: got %0d words left, wanted 1", exp_tx.size());
    else n_pass++;
    #2 R = 1'b0;
    #1;
    n_checks++;
    if ({txen, tx_cw, busy, done, err, fifo_cnt, tx_dat} !== 28'h0)
      $display("FAIL rst_async: got %h, wanted 0", {txen, tx_cw, busy, done, err, fifo_cnt, tx_dat});
    else n_pass++;
    exp_tx.delete();
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    R = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) $display("FAIL rst_no_done: got done pulse, wanted none");
    else n_pass++;
    go(5'd5, 5'd3, 1'b0, 5'd1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rst_restart_busy: got %b, wanted 1", busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || err !== 2'b11)
      $display("FAIL rst_restart_done: got done=%b err=%b, wanted 1 11", done, err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bc_rt();
    test_rt_bc();
    test_timeout();
    test_mismatch();
    test_underflow();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, wanted finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
